// File: rtl/step_ctrl.sv
// step_ctrl: debounced single-step / auto-repeat clock-enable generator.
//
// Purpose: turns a raw, bouncing step pushbutton and a raw run/step mode
// switch into a datapath clock enable. In free-run mode the enable is held
// high. In single-step mode a debounced press yields one enable cycle. A
// long hold then yields one more cycle per repeat interval.
//
// Ports:
//   clk        in   1  system clock (4.19 MHz PLL output)
//   rst        in   1  synchronous reset, active low
//   key_n      in   1  raw step pushbutton, asynchronous, low while pressed
//   run_sw     in   1  raw mode switch, asynchronous, 1 = free-run, 0 = step
//   step_ce    out  1  datapath clock enable (registered)
//   running    out  1  synchronized run mode (registered)
//   step_count out 16  single steps issued while in step mode (wraps)
module step_ctrl #(
  parameter int DEB_CYCLES    = 20000,
  parameter int HOLD_CYCLES   = 2095000,
  parameter int REPEAT_CYCLES = 419000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic        run_sw,
  output logic        step_ce,
  output logic        running,
  output logic [15:0] step_count
);

  // One shared counter, sized for the longest interval it has to time.
  localparam int MAX_AB  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DEB_PRESS   = 3'd1,
    S_PRESSED     = 3'd2,
    S_REPEAT      = 3'd3,
    S_DEB_RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_key_s1;
  logic               r_key_s2;
  logic               r_run_s1;
  logic               r_run_s2;
  logic               r_step_ce;
  logic [15:0]        r_step_count;
  logic               w_key_low;
  logic               w_pulse;

  assign w_key_low = ~r_key_s2;

  // Step pulse condition: true on the edge where the FSM issues a step.
  always_comb begin
    w_pulse = 1'b0;
    case (r_state)
      S_DEB_PRESS: begin
        if (w_key_low && (r_cnt == DEB_LAST)) w_pulse = 1'b1;
        else                                  w_pulse = 1'b0;
      end
      S_PRESSED: begin
        if (w_key_low && (r_cnt == HOLD_LAST)) w_pulse = 1'b1;
        else                                   w_pulse = 1'b0;
      end
      S_REPEAT: begin
        if (w_key_low && (r_cnt == REP_LAST)) w_pulse = 1'b1;
        else                                  w_pulse = 1'b0;
      end
      default: w_pulse = 1'b0;
    endcase
  end

  // Synchronizers, key FSM, and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key_s1     <= 1'b1;
      r_key_s2     <= 1'b1;
      r_run_s1     <= 1'b0;
      r_run_s2     <= 1'b0;
      r_state      <= S_IDLE;
      r_cnt        <= CNT_ZERO;
      r_step_ce    <= 1'b0;
      r_step_count <= 16'h0000;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      r_run_s1 <= run_sw;
      r_run_s2 <= r_run_s1;

      // r_run_s1 is the value running takes next cycle, so step_ce and
      // running line up exactly; pulses during free-run are absorbed.
      r_step_ce <= r_run_s1 | w_pulse;
      if (w_pulse && !r_run_s1) begin
        r_step_count <= r_step_count + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_key_low) begin
            r_state <= S_DEB_PRESS;
            r_cnt   <= CNT_ZERO;
          end
        end
        S_DEB_PRESS: begin
          if (!w_key_low) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= S_PRESSED;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!w_key_low) begin
            r_state <= S_DEB_RELEASE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= S_REPEAT;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_REPEAT: begin
          if (!w_key_low) begin
            r_state <= S_DEB_RELEASE;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == REP_LAST) begin
            r_cnt <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DEB_RELEASE: begin
          // A low sample restarts the release timer; the release must be
          // clean for the full window before a new press is accepted.
          if (w_key_low) begin
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign step_ce    = r_step_ce;
  assign running    = r_run_s2;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed testbench for step_ctrl with short debounce/hold/repeat times.
// Edge k is the k-th rising edge of a pattern run; inputs for edge k are
// driven on the preceding falling edge and outputs are sampled 1 time unit
// after edge k.
module tb_step_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int NPAT = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_n;
  logic        run_sw;
  logic        step_ce;
  logic        running;
  logic [15:0] step_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_count;

  logic key_pat [NPAT];
  logic run_pat [NPAT];
  logic rst_pat [NPAT];
  logic ce_log  [NPAT];
  logic run_log [NPAT];

  always #5 clk = ~clk;

  step_ctrl #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .run_sw    (run_sw),
    .step_ce   (step_ce),
    .running   (running),
    .step_count(step_count)
  );

  task automatic clear_pat();
    for (int i = 0; i < NPAT; i++) begin
      key_pat[i] = 1'b1;
      run_pat[i] = 1'b0;
      rst_pat[i] = 1'b1;
      ce_log[i]  = 1'b0;
      run_log[i] = 1'b0;
    end
  endtask

  task automatic run_pattern(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      key_n  = key_pat[k];
      run_sw = run_pat[k];
      rst    = rst_pat[k];
      @(posedge clk);
      #1;
      ce_log[k]  = step_ce;
      run_log[k] = running;
    end
  endtask

  task automatic settle();
    clear_pat();
    run_pattern(12);
  endtask

  task automatic test_reset();
    clear_pat();
    for (int k = 1; k <= 3; k++) begin
      rst_pat[k] = 1'b0;
      run_pat[k] = 1'b1;
    end
    run_pattern(3);
    n_checks++;
    if (step_ce !== 1'b0) begin
      n_fail++; $display("FAIL reset_step_ce: got %b expected 0", step_ce);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++; $display("FAIL reset_running: got %b expected 0", running);
    end
    n_checks++;
    if (step_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count: got %h expected 0000", step_count);
    end
    exp_count = 16'h0000;
    settle();
  endtask

  task automatic test_single_press();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 12; k++) key_pat[k] = 1'b0;
    run_pattern(30);
    for (int k = 1; k <= 30; k++) begin
      exp = (k == 7);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL single_press step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
    end
    exp_count = exp_count + 16'd1;
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL single_press count: got %h expected %h", step_count, exp_count);
    end
  endtask

  task automatic test_glitch();
    clear_pat();
    for (int k = 1; k <= 3; k++) key_pat[k] = 1'b0;
    run_pattern(20);
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if (ce_log[k] !== 1'b0) begin
        n_fail++; $display("FAIL glitch step_ce edge %0d: got %b expected 0", k, ce_log[k]);
      end
    end
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL glitch count: got %h expected %h", step_count, exp_count);
    end
  endtask

  task automatic test_autorepeat();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 60; k++) key_pat[k] = 1'b0;
    run_pattern(80);
    for (int k = 1; k <= 80; k++) begin
      exp = (k == 7) || (k == 27) || (k == 35) || (k == 43) || (k == 51) || (k == 59);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL autorepeat step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
    end
    exp_count = exp_count + 16'd6;
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL autorepeat count: got %h expected %h", step_count, exp_count);
    end
  endtask

  // Release bounces high 2, low 1, high 10; a fresh press afterwards must
  // see the full IDLE latency, which only happens if the FSM reached IDLE.
  task automatic test_bounce();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 12; k++) key_pat[k] = 1'b0;
    key_pat[15] = 1'b0;
    for (int k = 26; k <= 40; k++) key_pat[k] = 1'b0;
    run_pattern(60);
    for (int k = 1; k <= 60; k++) begin
      exp = (k == 7) || (k == 32);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL bounce step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
    end
    exp_count = exp_count + 16'd2;
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL bounce count: got %h expected %h", step_count, exp_count);
    end
  endtask

  task automatic test_run_mode();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 10; k++) run_pat[k] = 1'b1;
    run_pattern(20);
    for (int k = 1; k <= 20; k++) begin
      exp = (k >= 2) && (k <= 11);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL run_mode step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
      n_checks++;
      if (run_log[k] !== exp) begin
        n_fail++;
        $display("FAIL run_mode running edge %0d: got %b expected %b", k, run_log[k], exp);
      end
    end
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL run_mode count: got %h expected %h", step_count, exp_count);
    end
  endtask

  // Press accepted during free-run, still held when run mode ends: the
  // press is consumed and no step is issued or counted.
  task automatic test_run_press();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 20; k++) run_pat[k] = 1'b1;
    for (int k = 1; k <= 22; k++) key_pat[k] = 1'b0;
    run_pattern(40);
    for (int k = 1; k <= 40; k++) begin
      exp = (k >= 2) && (k <= 21);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL run_press step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
    end
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL run_press count: got %h expected %h", step_count, exp_count);
    end
  endtask

  task automatic test_reset_midpress();
    logic exp;
    clear_pat();
    for (int k = 1; k <= 18; k++) key_pat[k] = 1'b0;
    for (int k = 6; k <= 8; k++) rst_pat[k] = 1'b0;
    run_pattern(35);
    for (int k = 1; k <= 35; k++) begin
      exp = (k == 15);
      n_checks++;
      if (ce_log[k] !== exp) begin
        n_fail++;
        $display("FAIL reset_midpress step_ce edge %0d: got %b expected %b", k, ce_log[k], exp);
      end
    end
    exp_count = 16'h0001;
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL reset_midpress count: got %h expected %h", step_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_step_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_step_count;
    exp_count = 16'hFFFF;
    n_checks++;
    if (step_count !== exp_count) begin
      n_fail++; $display("FAIL wrap_preload: got %h expected %h", step_count, exp_count);
    end
    clear_pat();
    for (int k = 1; k <= 12; k++) key_pat[k] = 1'b0;
    run_pattern(30);
    n_checks++;
    if (ce_log[7] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pulse: got %b expected 1", ce_log[7]);
    end
    exp_count = exp_count + 16'd1;
    n_checks++;
    if (step_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_count: got %h expected 0000", step_count);
    end
  endtask

  initial begin
    rst    = 1'b0;
    key_n  = 1'b1;
    run_sw = 1'b0;
    exp_count = 16'h0000;
    test_reset();
    test_single_press();
    test_glitch();
    test_autorepeat();
    test_bounce();
    test_run_mode();
    test_run_press();
    test_reset_midpress();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 20000, meaning consecutive stable cycles needed to accept a key press or release.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2095000, meaning cycles a press must be held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 419000, meaning cycles between auto-repeat steps.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the 4.19 MHz PLL output.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port key_n, input, 1 bit: raw step pushbutton, asynchronous, low while pressed.
REQ-007 SHALL have port run_sw, input, 1 bit: raw mode switch, asynchronous; 1 selects free-run, 0 selects single-step.
REQ-008 SHALL have port step_ce, output, 1 bit: clock enable for the datapath.
REQ-009 SHALL have port running, output, 1 bit: synchronized run mode.
REQ-010 SHALL have port step_count, output, 16 bits: number of single steps issued, for the hex displays.

Function
REQ-011 SHALL pass key_n and run_sw each through a 2-flop synchronizer; all logic after that uses only the synchronized values.
REQ-012 SHALL implement an FSM with states IDLE, DEB_PRESS, PRESSED, REPEAT and DEB_RELEASE, plus one counter wide enough for the largest parameter.
- IDLE: synced key low -> DEB_PRESS with counter = 0.
- DEB_PRESS: key low and counter = DEB_CYCLES-1 -> PRESSED, one step pulse, counter = 0. Otherwise key low -> counter increments. Key high -> IDLE, no pulse.
- PRESSED: key high -> DEB_RELEASE with counter = 0. Key low and counter = HOLD_CYCLES-1 -> REPEAT, one step pulse, counter = 0. Otherwise counter increments.
- REPEAT: key high -> DEB_RELEASE with counter = 0. Key low and counter = REPEAT_CYCLES-1 -> one step pulse, counter = 0. Otherwise counter increments.
- DEB_RELEASE: key high and counter = DEB_CYCLES-1 -> IDLE. Key high otherwise -> counter increments. Key low -> counter = 0, stay in DEB_RELEASE, no pulse.
REQ-013 SHALL register the step pulse, making it high for exactly one cycle, in the cycle after the transition edge.
REQ-014 SHALL assert the first step pulse in the cycle after rising edge DEB_CYCLES+3, counting the first edge that samples key_n low as edge 1, provided key_n stays low throughout.
REQ-015 SHALL drive step_ce = 1 continuously while running = 1; while running = 0, step_ce SHALL equal the step pulse.
REQ-016 SHALL keep the FSM running in both modes; pulses produced while running = 1 SHALL NOT have any further effect.
REQ-017 SHALL increment step_count by 1 on each step pulse while running = 0, and SHALL NOT increment it while running = 1.
REQ-018 SHALL wrap step_count from 16'hFFFF to 16'h0000 without a flag.
REQ-019 SHALL, when running falls, drop step_ce in the next cycle unless a step pulse is issued in that same cycle.
REQ-020 SHALL treat a key press that is already debounced when running falls as consumed; no extra pulse SHALL result.
REQ-021 SHALL NOT exceed one step_ce cycle per accepted press in step mode, plus one per auto-repeat interval.
REQ-022 SHALL NOT allow glitches shorter than DEB_CYCLES on either edge of the key to produce a pulse.

Reset
REQ-023 SHALL, while rst = 0 at a clock edge, set state = IDLE, counter = 0, key synchronizer flops = 1, run synchronizer flops = 0, step_ce = 0, running = 0 and step_count = 0.
REQ-024 SHALL abort any press in progress on reset; after rst rises, a key still held SHALL be re-debounced from IDLE and SHALL yield exactly one new pulse after the REQ-014 latency.
REQ-025 SHALL make reset take priority over all other events in the same cycle.

Verification (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-026 SHALL cover: key_n low for 12 cycles, then high, with run_sw=0 -> one step_ce pulse, in the cycle after edge 7, and step_count = 1.
REQ-027 SHALL cover: key_n low for 3 cycles, then high, with run_sw=0 -> no step_ce pulse and step_count = 0.
REQ-028 SHALL cover: key_n held low for 60 cycles with run_sw=0 -> pulses after edges 7, 27, 35, 43, 51 and 59, then step_count = 6.
REQ-029 SHALL cover: on release, key_n bounces high 2, low 1, high 10 -> no extra pulse and the FSM reaches IDLE.
REQ-030 SHALL cover: run_sw=1 for 10 cycles, then 0 -> step_ce high continuously from the cycle after edge 2 until 2 cycles after run_sw falls, with step_count unchanged.
REQ-031 SHALL cover: step_count preloaded to 16'hFFFF via 65535 accepted presses (or a forced value), then one more press -> step_count = 16'h0000.
REQ-032 SHALL cover: rst=0 asserted in DEB_PRESS with key_n held low, then released to 1 -> one pulse after the REQ-014 latency measured from the first edge with rst=1.
